avst_frame_fifo: RTL and testbench

AVST_FRAME_FIFO -- requirements
Module: avst_frame_fifo

---
 rtl/avst_frame_fifo.sv | 191 +++++++++++++++++++
 tb/tb_avst_frame_fifo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_frame_fifo.sv
// Store-and-forward frame FIFO for an Avalon-ST receive stream.
// Beats are written speculatively behind commit_ptr and only become visible
// to the read side once the frame's eop beat is accepted without error.
// Bad, truncated or overflowing frames are rolled back and counted.
// Output latency: with no committed data pending, out_valid asserts on the
// clock edge that follows the edge accepting the committing eop beat
// (one cycle).
module avst_frame_fifo #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic [31:0]       in_data,
    input  logic              in_sop,
    input  logic              in_eop,
    input  logic [1:0]        in_empty,
    input  logic [5:0]        in_error,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [31:0]       out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic [1:0]        out_empty,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int PW    = ADDR_W + 1;
    localparam logic [PW-1:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0] ONE_P   = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        DISCARD = 2'd2
    } wstate_t;

    // storage and state
    logic [35:0]      mem_r [DEPTH];
    wstate_t          state_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    commit_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] drop_count_r;
    logic             overflow_r;
    logic             in_ready_r;
    logic [31:0]      out_data_r;
    logic             out_sop_r;
    logic             out_eop_r;
    logic [1:0]       out_empty_r;
    logic             out_valid_r;

    // write-side decode
    wstate_t          state_nxt_s;
    logic [PW-1:0]    wr_ptr_nxt_s;
    logic [PW-1:0]    commit_ptr_nxt_s;
    logic             mem_we_s;
    logic [1:0]       drop_inc_s;
    logic             ovf_set_s;
    logic             accept_s;
    logic             roll_s;
    logic [PW-1:0]    base_ptr_s;
    logic [PW-1:0]    used_s;
    logic             full_s;
    logic [CNT_W:0]   drop_sum_s;
    logic [CNT_W-1:0] drop_nxt_s;

    // read-side decode
    logic             avail_s;
    logic             load_s;
    logic [35:0]      rd_word_s;

    assign accept_s = in_valid & in_ready_r;
    // A sop while receiving abandons the partial frame in progress.
    assign roll_s   = accept_s & in_sop & (state_r == RECV);
    // A sop always starts a fresh frame at commit_ptr; a continuation beat
    // goes to wr_ptr (in IDLE/DISCARD the two are equal anyway).
    assign base_ptr_s = ((state_r == RECV) && !in_sop) ? wr_ptr_r : commit_ptr_r;
    assign used_s     = base_ptr_s - rd_ptr_r;
    assign full_s     = (used_s == DEPTH_P);

    assign drop_sum_s = {1'b0, drop_count_r} + {{(CNT_W-1){1'b0}}, drop_inc_s};
    assign drop_nxt_s = drop_sum_s[CNT_W] ? {CNT_W{1'b1}} : drop_sum_s[CNT_W-1:0];

    assign avail_s   = (commit_ptr_r != rd_ptr_r);
    assign load_s    = avail_s & (~out_valid_r | out_ready);
    assign rd_word_s = mem_r[rd_ptr_r[ADDR_W-1:0]];

    // Write FSM next state, pointer updates and drop accounting.
    always_comb begin
        state_nxt_s      = state_r;
        wr_ptr_nxt_s     = wr_ptr_r;
        commit_ptr_nxt_s = commit_ptr_r;
        mem_we_s         = 1'b0;
        drop_inc_s       = 2'd0;
        ovf_set_s        = 1'b0;
        if (!accept_s) begin
            state_nxt_s = state_r;
        end else if (in_sop || (state_r == RECV)) begin
            wr_ptr_nxt_s = commit_ptr_r;
            if (full_s) begin
                drop_inc_s  = roll_s ? 2'd2 : 2'd1;
                ovf_set_s   = 1'b1;
                state_nxt_s = in_eop ? IDLE : DISCARD;
            end else if (in_eop && (in_error != 6'd0)) begin
                drop_inc_s  = roll_s ? 2'd2 : 2'd1;
                state_nxt_s = IDLE;
            end else if (!in_eop && (in_empty != 2'd0)) begin
                drop_inc_s  = roll_s ? 2'd2 : 2'd1;
                state_nxt_s = DISCARD;
            end else begin
                mem_we_s     = 1'b1;
                wr_ptr_nxt_s = base_ptr_s + ONE_P;
                drop_inc_s   = roll_s ? 2'd1 : 2'd0;
                if (in_eop) begin
                    commit_ptr_nxt_s = base_ptr_s + ONE_P;
                    state_nxt_s      = IDLE;
                end else begin
                    state_nxt_s = RECV;
                end
            end
        end else if (state_r == DISCARD) begin
            state_nxt_s = in_eop ? IDLE : DISCARD;
        end else begin
            state_nxt_s = IDLE;
        end
    end

    // Write FSM state, pointers, counters and ready flag.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            wr_ptr_r     <= {PW{1'b0}};
            commit_ptr_r <= {PW{1'b0}};
            drop_count_r <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
            in_ready_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            wr_ptr_r     <= wr_ptr_nxt_s;
            commit_ptr_r <= commit_ptr_nxt_s;
            drop_count_r <= drop_nxt_s;
            overflow_r   <= overflow_r | ovf_set_s;
            in_ready_r   <= 1'b1;
        end
    end

    // Frame storage; contents are don't-care until covered by commit_ptr.
    always_ff @(posedge sys_clk) begin
        if (mem_we_s) begin
            mem_r[base_ptr_s[ADDR_W-1:0]] <= {in_sop, in_eop, in_empty, in_data};
        end
    end

    // Output register: refill from committed storage whenever empty or popped.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_r    <= {PW{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= 32'd0;
            out_sop_r   <= 1'b0;
            out_eop_r   <= 1'b0;
            out_empty_r <= 2'd0;
        end else if (load_s) begin
            rd_ptr_r    <= rd_ptr_r + ONE_P;
            out_valid_r <= 1'b1;
            out_sop_r   <= rd_word_s[35];
            out_eop_r   <= rd_word_s[34];
            out_empty_r <= rd_word_s[33:32];
            out_data_r  <= rd_word_s[31:0];
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_data   = out_data_r;
    assign out_sop    = out_sop_r;
    assign out_eop    = out_eop_r;
    assign out_empty  = out_empty_r;
    assign out_valid  = out_valid_r;
    assign drop_count = drop_count_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_avst_frame_fifo.sv
// Testbench for avst_frame_fifo (DEPTH = 16 words).
module tb_avst_frame_fifo;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = 16;

    logic             sys_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [31:0]      in_data = 32'd0;
    logic             in_sop = 1'b0;
    logic             in_eop = 1'b0;
    logic [1:0]       in_empty = 2'd0;
    logic [5:0]       in_error = 6'd0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      out_data;
    logic             out_sop;
    logic             out_eop;
    logic [1:0]       out_empty;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    avst_frame_fifo #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n),
        .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
        .in_empty(in_empty), .in_error(in_error), .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
        .out_empty(out_empty), .out_valid(out_valid), .out_ready(out_ready),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        logic [5:0]  error;
        logic        exp_out;
        logic        chk;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t        tbl[$];
    logic [35:0] cap_q[$];
    logic [35:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Record every output handshake, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (reset_n && out_valid && out_ready)
            cap_q.push_back({out_sop, out_eop, out_empty, out_data});
    end

    function automatic vec_t mk(input logic [31:0] d, input logic s, input logic e,
                                input logic [1:0] em, input logic [5:0] er,
                                input logic o, input logic c, input logic [15:0] dr);
        vec_t v;
        v.data = d; v.sop = s; v.eop = e; v.empty = em; v.error = er;
        v.exp_out = o; v.chk = c; v.exp_drop = dr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic s, input logic e,
                        input logic [1:0] em, input logic [5:0] er);
        in_data = d; in_sop = s; in_eop = e; in_empty = em; in_error = er;
        in_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_empty = 2'd0; in_error = 6'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_frames(input string name);
        logic [35:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (cap_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: actual no beat required %0h", name, e);
            end else begin
                check(name, 64'(cap_q.pop_front()), 64'(e));
            end
        end
        check({name, " extra"}, 64'(cap_q.size()), 64'd0);
        cap_q.delete();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, " in_ready"},   64'(in_ready),   64'd0);
        check({tag, " out_valid"},  64'(out_valid),  64'd0);
        check({tag, " out_sop"},    64'(out_sop),    64'd0);
        check({tag, " out_eop"},    64'(out_eop),    64'd0);
        check({tag, " out_data"},   64'(out_data),   64'd0);
        check({tag, " out_empty"},  64'(out_empty),  64'd0);
        check({tag, " drop_count"}, 64'(drop_count), 64'd0);
        check({tag, " overflow"},   64'(overflow),   64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stream of frames, out_ready=1; exp_out marks beats that must emerge.
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(32'(i), (i == 1), (i == 16), 2'd0, 6'd0, 1'b1, (i == 16), 16'd0));
        tbl.push_back(mk(32'h100, 1'b1, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(32'h101, 1'b0, 1'b0, 2'd0, 6'd0,  1'b0, 1'b0, 16'd0));
        tbl.push_back(mk(32'h102, 1'b0, 1'b1, 2'd0, 6'h01, 1'b0, 1'b0, 16'd0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(32'h200 + 32'(i), (i == 0), (i == 3), 2'd0, 6'd0, 1'b1, (i == 3), 16'd1));
        tbl.push_back(mk(32'h300, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 16'd1));
        tbl.push_back(mk(32'h301, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 16'd1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(32'h400 + 32'(i), (i == 0), (i == 4), 2'd0, 6'd0, 1'b1, (i == 4), 16'd2));
        tbl.push_back(mk(32'h500, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 16'd2));
        tbl.push_back(mk(32'h501, 1'b0, 1'b0, 2'd2, 6'd0, 1'b0, 1'b0, 16'd2));
        tbl.push_back(mk(32'h502, 1'b0, 1'b1, 2'd0, 6'd0, 1'b0, 1'b0, 16'd2));
        tbl.push_back(mk(32'h600, 1'b1, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 16'd3));
        tbl.push_back(mk(32'h601, 1'b0, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 16'd3));
        tbl.push_back(mk(32'h602, 1'b0, 1'b1, 2'd3, 6'd0, 1'b1, 1'b1, 16'd3));
        tbl.push_back(mk(32'h700, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 16'd3));
        tbl.push_back(mk(32'h800, 1'b1, 1'b1, 2'd1, 6'd0, 1'b1, 1'b1, 16'd3));
        tbl.push_back(mk(32'h900, 1'b1, 1'b1, 2'd0, 6'h20, 1'b0, 1'b0, 16'd4));
        tbl.push_back(mk(32'hA00, 1'b1, 1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 16'd4));
        tbl.push_back(mk(32'hA01, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0, 1'b0, 16'd5));
        tbl.push_back(mk(32'hA02, 1'b1, 1'b0, 2'd0, 6'd0, 1'b1, 1'b0, 16'd5));
        tbl.push_back(mk(32'hA03, 1'b0, 1'b1, 2'd0, 6'd0, 1'b1, 1'b1, 16'd5));

        // Reset values.
        #3;
        reset_checks("reset");
        #9;
        reset_n = 1'b1;
        idle(1);
        check("in_ready after release", 64'(in_ready), 64'd1);

        // Store-and-forward and commit-to-output latency.
        send(32'h10, 1'b1, 1'b0, 2'd0, 6'd0);
        check("saf beat1 out_valid", 64'(out_valid), 64'd0);
        send(32'h11, 1'b0, 1'b0, 2'd0, 6'd0);
        check("saf beat2 out_valid", 64'(out_valid), 64'd0);
        send(32'h12, 1'b0, 1'b0, 2'd0, 6'd0);
        check("saf beat3 out_valid", 64'(out_valid), 64'd0);
        send(32'h13, 1'b0, 1'b1, 2'd0, 6'd0);
        check("saf eop edge out_valid", 64'(out_valid), 64'd0);
        idle(1);
        check("latency out_valid", 64'(out_valid), 64'd1);
        check("latency out_data", 64'(out_data), 64'h10);
        check("latency out_sop", 64'(out_sop), 64'd1);
        idle(8);
        exp_q.push_back({1'b1, 1'b0, 2'd0, 32'h10});
        exp_q.push_back({1'b0, 1'b0, 2'd0, 32'h11});
        exp_q.push_back({1'b0, 1'b0, 2'd0, 32'h12});
        exp_q.push_back({1'b0, 1'b1, 2'd0, 32'h13});
        check_frames("saf frame");

        // Table-driven frame stream.
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].data, tbl[i].sop, tbl[i].eop, tbl[i].empty, tbl[i].error);
            if (tbl[i].exp_out)
                exp_q.push_back({tbl[i].sop, tbl[i].eop, tbl[i].empty, tbl[i].data});
            if (tbl[i].chk) begin
                idle(24);
                check_frames($sformatf("tbl[%0d] beats", i));
                check($sformatf("tbl[%0d] drop_count", i), 64'(drop_count), 64'(tbl[i].exp_drop));
            end
        end
        check("overflow after table", 64'(overflow), 64'd0);

        // Overflow: 8-beat frame fits, 12-beat frame does not.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(32'hB00 + 32'(i), (i == 0), (i == 7), 2'd0, 6'd0);
        for (int i = 0; i < 12; i++)
            send(32'hC00 + 32'(i), (i == 0), (i == 11), 2'd0, 6'd0);
        idle(3);
        check("ovf overflow", 64'(overflow), 64'd1);
        check("ovf drop_count", 64'(drop_count), 64'd6);
        check("ovf hold out_valid", 64'(out_valid), 64'd1);
        check("ovf hold out_data", 64'(out_data), 64'hB00);
        idle(3);
        check("ovf stable out_data", 64'(out_data), 64'hB00);
        check("ovf stable out_sop", 64'(out_sop), 64'd1);
        out_ready = 1'b1;
        idle(8);
        check("ovf back-to-back count", 64'(cap_q.size()), 64'd8);
        idle(20);
        for (int i = 0; i < 8; i++)
            exp_q.push_back({(i == 0), (i == 7), 2'd0, 32'hB00 + 32'(i)});
        check_frames("ovf frame");
        check("ovf sticky", 64'(overflow), 64'd1);

        // Reset during beat 6 of a 10-beat frame with a frame waiting at the output.
        out_ready = 1'b0;
        send(32'hE00, 1'b1, 1'b0, 2'd0, 6'd0);
        send(32'hE01, 1'b0, 1'b1, 2'd0, 6'd0);
        idle(3);
        check("pre-reset out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++)
            send(32'hD00 + 32'(i), (i == 0), 1'b0, 2'd0, 6'd0);
        in_data = 32'hD05;
        in_valid = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        reset_checks("mid-frame reset");
        in_valid = 1'b0;
        @(posedge sys_clk);
        #3;
        reset_n = 1'b1;
        idle(2);
        out_ready = 1'b1;
        for (int i = 6; i < 10; i++)
            send(32'hD00 + 32'(i), 1'b0, (i == 9), 2'd0, 6'd0);
        idle(10);
        check("post-reset no output", 64'(cap_q.size()), 64'd0);
        check("post-reset drop_count", 64'(drop_count), 64'd0);
        send(32'hF00, 1'b1, 1'b0, 2'd0, 6'd0);
        send(32'hF01, 1'b0, 1'b1, 2'd2, 6'd0);
        idle(6);
        exp_q.push_back({1'b1, 1'b0, 2'd0, 32'hF00});
        exp_q.push_back({1'b0, 1'b1, 2'd2, 32'hF01});
        check_frames("post-reset frame");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
